// File: rtl/stack_machine_ctrl.sv
// stack_machine_ctrl: loads the core's instruction memory from a host command stream and sequences run, step and halt.
module stack_machine_ctrl #(
   parameter int PC_W   = 5,
   parameter int INST_W = 12,
   parameter int CYC_W  = 16
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [INST_W-1:0] i_cmd_data,
   input  logic [PC_W-1:0]   i_core_pc,
   input  logic              i_core_error,
   output logic              o_core_en,
   output logic              o_core_clr,
   output logic              o_imem_we,
   output logic [PC_W-1:0]   o_imem_addr,
   output logic [INST_W-1:0] o_imem_wdata,
   input  logic              i_bp_en,
   input  logic [PC_W-1:0]   i_bp_addr,
   input  logic [CYC_W-1:0]  i_cycle_limit,
   output logic [2:0]        o_state,
   output logic [CYC_W-1:0]  o_cycles,
   output logic              o_done,
   output logic [2:0]        o_halt_cause
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_STEP, S_HALTED} state_t;
   localparam logic [1:0] OP_LOAD = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_HALT = 2'd3;
   localparam logic [2:0] C_NONE = 3'd0, C_HOST = 3'd1, C_BP = 3'd2, C_ERR = 3'd3, C_LIMIT = 3'd4, C_STEP = 3'd5;
   localparam logic [PC_W:0] DEPTH = {1'b1, {PC_W{1'b0}}};

   state_t           r_state, w_state, r_after, w_after;
   logic [PC_W:0]    r_n, w_n, r_ptr, w_ptr, w_hdr;
   logic [CYC_W-1:0] r_cycles, w_cycles;
   logic [2:0]       r_cause, w_cause;
   logic             r_first, w_first, w_acc, w_err, w_lim, w_bp, w_hit;

   assign o_cmd_ready  = r_state != S_CLEAR && r_state != S_STEP;
   assign w_acc        = i_cmd_valid && o_cmd_ready;
   assign w_hdr        = i_cmd_data[PC_W:0] > DEPTH ? DEPTH : i_cmd_data[PC_W:0];
   assign w_err        = i_core_error;
   assign w_lim        = i_cycle_limit != '0 && r_cycles == i_cycle_limit;
   assign w_bp         = i_bp_en && i_core_pc == i_bp_addr && !r_first;
   assign w_hit        = w_err || w_lim || w_bp;
   assign o_imem_we    = r_state == S_LOAD && w_acc;
   assign o_imem_addr  = r_state == S_LOAD ? r_ptr[PC_W-1:0] : '0;
   assign o_imem_wdata = r_state == S_LOAD ? i_cmd_data : '0;
   assign o_state      = r_state;
   assign o_cycles     = r_cycles;
   assign o_done       = r_state == S_HALTED;
   assign o_halt_cause = r_cause;

   always_comb begin
      w_state    = r_state;
      w_after    = r_after;
      w_n        = r_n;
      w_ptr      = r_ptr;
      w_cycles   = r_cycles;
      w_cause    = r_cause;
      w_first    = r_first;
      o_core_en  = 1'b0;
      o_core_clr = 1'b0;
      case (r_state)
         S_IDLE, S_HALTED: if (w_acc) begin
            if (i_cmd_op == OP_LOAD && w_hdr != '0) begin
               w_state = S_LOAD;
               w_n     = w_hdr;
               w_ptr   = '0;
            end else if (i_cmd_op == OP_RUN) begin
               // resuming from HALTED skips the clear and masks the breakpoint for one cycle
               w_state = r_state == S_IDLE ? S_CLEAR : S_RUN;
               w_after = S_RUN;
               w_first = r_state == S_HALTED;
            end else if (i_cmd_op == OP_STEP) begin
               w_state = r_state == S_IDLE ? S_CLEAR : S_STEP;
               w_after = S_STEP;
            end else if (i_cmd_op == OP_HALT && r_state == S_HALTED) begin
               w_state = S_IDLE;
               w_cause = C_NONE;
            end
         end
         S_LOAD: if (w_acc) begin
            w_ptr = r_ptr + 1'b1;
            if (w_ptr == r_n) w_state = S_IDLE;
         end
         S_CLEAR: begin
            o_core_clr = 1'b1;
            w_cycles   = '0;
            w_cause    = C_NONE;
            w_state    = r_after;
         end
         S_RUN: begin
            o_core_en = !w_hit;
            w_first   = 1'b0;
            if (w_hit) begin
               w_state = S_HALTED;
               w_cause = w_err ? C_ERR : w_lim ? C_LIMIT : C_BP;
            end else if (w_acc && i_cmd_op == OP_HALT) begin
               w_state = S_HALTED;
               w_cause = C_HOST;
            end
         end
         S_STEP: begin
            o_core_en = !w_err;
            w_state   = S_HALTED;
            w_cause   = w_err ? C_ERR : C_STEP;
         end
         default: w_state = S_IDLE;
      endcase
      if (o_core_en && !(&r_cycles)) w_cycles = r_cycles + 1'b1;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state  <= S_IDLE;
         r_after  <= S_RUN;
         r_n      <= '0;
         r_ptr    <= '0;
         r_cycles <= '0;
         r_cause  <= C_NONE;
         r_first  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_after  <= w_after;
         r_n      <= w_n;
         r_ptr    <= w_ptr;
         r_cycles <= w_cycles;
         r_cause  <= w_cause;
         r_first  <= w_first;
      end
   end
endmodule

// File: tb/tb_stack_machine_ctrl.sv
// tb_stack_machine_ctrl: directed stimulus with queued expectations for memory writes and halt reports.
module tb_stack_machine_ctrl;
   localparam logic [1:0] OP_LOAD = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_HALT = 2'd3;

   typedef struct {int addr; int data;} wr_t;
   typedef struct {int cyc; int cause; int pc;} halt_t;

   logic        clk = 1'b0, rstN = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [11:0] cmd_data = '0;
   logic [4:0]  core_pc;
   logic        core_error = 1'b0, core_en, core_clr;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [11:0] imem_wdata;
   logic        bp_en = 1'b0;
   logic [4:0]  bp_addr = '0;
   logic [15:0] cycle_limit = '0;
   logic [2:0]  state, halt_cause;
   logic [15:0] cycles;
   logic        done;

   int    n_tests = 0, n_fail = 0, en_cnt = 0, clr_cnt = 0;
   logic  loop_mode = 1'b0, prev_done = 1'b0;
   wr_t   wq[$];
   halt_t hq[$];

   stack_machine_ctrl dut (
      .clk(clk), .rstN(rstN), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_op(cmd_op), .i_cmd_data(cmd_data), .i_core_pc(core_pc), .i_core_error(core_error),
      .o_core_en(core_en), .o_core_clr(core_clr), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
      .o_imem_wdata(imem_wdata), .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_cycle_limit(cycle_limit),
      .o_state(state), .o_cycles(cycles), .o_done(done), .o_halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   // core stand-in: straight-line program, or a four-instruction loop
   always @(posedge clk or negedge rstN) begin
      if (!rstN) core_pc <= '0;
      else if (core_clr) core_pc <= '0;
      else if (core_en) core_pc <= (loop_mode && core_pc == 5'd3) ? 5'd0 : core_pc + 5'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (core_en) en_cnt++;
      if (core_clr) clr_cnt++;
      if (imem_we) begin
         if (wq.size() == 0) check("unexpected_write", 1, 0);
         else begin
            wr_t w;
            w = wq.pop_front();
            check("imem_addr", int'(imem_addr), w.addr);
            check("imem_wdata", int'(imem_wdata), w.data);
         end
      end
      if (done && !prev_done) begin
         if (hq.size() == 0) check("unexpected_halt", 1, 0);
         else begin
            halt_t h;
            h = hq.pop_front();
            check("halt_cycles", int'(cycles), h.cyc);
            check("halt_cause", int'(halt_cause), h.cause);
            check("halt_pc", int'(core_pc), h.pc);
         end
      end
      prev_done = done;
   end

   task automatic beat(input logic [1:0] op, input logic [11:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("wait_done", int'(done), 1);
   endtask

   task automatic check_reset();
      check("rst_state", int'(state), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_core_en", int'(core_en), 0);
      check("rst_core_clr", int'(core_clr), 0);
      check("rst_we", int'(imem_we), 0);
      check("rst_addr", int'(imem_addr), 0);
      check("rst_wdata", int'(imem_wdata), 0);
      check("rst_cycles", int'(cycles), 0);
      check("rst_done", int'(done), 0);
      check("rst_cause", int'(halt_cause), 0);
   endtask

   initial begin
      int en0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rstN = 1'b1;
      // load three words; the middle beat uses a non-LOAD opcode
      wq.push_back('{0, 12'h001});
      wq.push_back('{1, 12'h0FF});
      wq.push_back('{2, 12'h305});
      beat(OP_LOAD, 12'd3);
      beat(OP_LOAD, 12'h001);
      beat(OP_RUN, 12'h0FF);
      beat(OP_LOAD, 12'h305);
      check("load_end_state", int'(state), 0);
      beat(OP_LOAD, 12'd0);
      check("load_zero_state", int'(state), 0);
      // breakpoint at pc 4, then resume past it and stop by host
      bp_en = 1'b1;
      bp_addr = 5'd4;
      hq.push_back('{4, 2, 4});
      beat(OP_RUN, 12'd0);
      check("clear_pulse", int'(core_clr), 1);
      wait_done();
      hq.push_back('{7, 1, 7});
      beat(OP_RUN, 12'd0);
      repeat (2) begin @(posedge clk); #1; end
      check("past_bp_pc", int'(core_pc), 6);
      beat(OP_HALT, 12'd0);
      wait_done();
      beat(OP_HALT, 12'd0);
      check("halt_to_idle", int'(state), 0);
      check("cause_cleared", int'(halt_cause), 0);
      // cycle budget on a loop; a second RUN must halt with no enable pulse
      bp_en = 1'b0;
      loop_mode = 1'b1;
      cycle_limit = 16'd10;
      hq.push_back('{10, 4, 2});
      beat(OP_RUN, 12'd0);
      wait_done();
      en0 = en_cnt;
      hq.push_back('{10, 4, 2});
      beat(OP_RUN, 12'd0);
      wait_done();
      check("limit_no_en", en_cnt, en0);
      cycle_limit = '0;
      beat(OP_HALT, 12'd0);
      // single step from IDLE, then three more
      en0 = en_cnt;
      clr_cnt = 0;
      hq.push_back('{1, 5, 1});
      beat(OP_STEP, 12'd0);
      wait_done();
      check("step_clr_cnt", clr_cnt, 1);
      check("step_en_cnt", en_cnt - en0, 1);
      hq.push_back('{2, 5, 2});
      hq.push_back('{3, 5, 3});
      hq.push_back('{4, 5, 0});
      for (int i = 0; i < 3; i++) begin
         beat(OP_STEP, 12'd0);
         wait_done();
      end
      check("step_cycles", int'(cycles), 4);
      beat(OP_HALT, 12'd0);
      // error and host halt in the same cycle
      loop_mode = 1'b0;
      hq.push_back('{2, 3, 2});
      beat(OP_RUN, 12'd0);
      repeat (3) begin @(posedge clk); #1; end
      cmd_valid = 1'b1;
      cmd_op = OP_HALT;
      core_error = 1'b1;
      @(negedge clk);
      check("err_core_en", int'(core_en), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      core_error = 1'b0;
      wait_done();
      beat(OP_HALT, 12'd0);
      // asynchronous reset in the middle of a run
      beat(OP_RUN, 12'd0);
      repeat (3) begin @(posedge clk); #1; end
      check("run_before_rst", int'(state), 3);
      rstN = 1'b0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      check("post_rst_ready", int'(cmd_ready), 1);
      repeat (2) @(posedge clk);
      check("writes_left", wq.size(), 0);
      check("halts_left", hq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
